pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle instruction sequencer that owns the architectural PC and drives the next-PC unit. It fetches each instruction over a valid/ready memory interface and presents the instruction and PC to the decode/next-PC datapath. It then commits the computed next PC, or halts or traps, so the single-cycle datapath can run against a memory with variable latency.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- FETCH_TIMEOUT, 255, maximum cycles spent in REQ+RESP before a fetch-timeout trap (8-bit counter)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- io_imem_req_valid  out  1  fetch request valid
- io_imem_req_ready  in  1  memory accepts request
- io_imem_req_addr  out  32  fetch address (= PC)
- io_imem_resp_valid  in  1  fetch data valid
- io_imem_resp_data  in  32  fetched instruction
- io_instruction  out  32  latched instruction to decoder/next-PC unit
- io_pc_count  out  32  current PC to next-PC unit
- io_pc_next_type  in  4  decoder jump/branch class (1 jal, 2 jalr, 3 unknown, 4 halt, 5–10 branches, other = sequential)
- io_pc_next  in  32  next PC from next-PC unit
- io_is_unknown_instruction  in  1  unknown-opcode flag from next-PC unit
- io_exec  out  1  high in EXEC; datapath evaluates
- io_wb_en  out  1  one-cycle register-file write/commit strobe
- io_halted  out  1  sticky, in HALT
- io_trapped  out  1  sticky, in TRAP
- io_trap_cause  out  2  0 none, 1 unknown instr, 2 misaligned target, 3 fetch timeout
- io_retired  out  32  retired-instruction count (see Configuration)

## Operation
- States: IDLE, REQ, RESP, EXEC, COMMIT, HALT, TRAP.
- IDLE: entered on reset; moves to REQ on the first clock after reset deasserts.
- REQ: req_valid=1 and req_addr=PC, both held stable until req_ready; on req_ready go to RESP. resp_valid in REQ is ignored.
- RESP: on resp_valid latch resp_data into the instruction register and go to EXEC.
- The timeout counter clears on REQ entry and increments every REQ/RESP cycle. When it reaches FETCH_TIMEOUT without completing: TRAP, cause 3. If completion and timeout occur in the same cycle, completion wins.
- EXEC: io_exec=1 for one cycle; io_instruction and io_pc_count are stable from EXEC through COMMIT.
- COMMIT, priority order:
  - io_is_unknown_instruction or type 3 → TRAP, cause 1.
  - type 4 → HALT; PC unchanged; no wb_en.
  - io_pc_next[1:0]≠0 → TRAP, cause 2; PC unchanged.
  - Otherwise wb_en=1, PC←io_pc_next, io_retired+1, go to REQ.
- HALT and TRAP are terminal until reset. All outputs hold; req_valid=0, io_exec=0, wb_en=0.
- Arithmetic: io_retired wraps 32'hFFFF_FFFF→0. PC is taken verbatim from io_pc_next; no internal adder.

## Timing
- Reset values: PC=RESET_PC; instruction reg=32'h0000_0013 (nop); req_valid=0, exec=0, wb_en=0, halted=0, trapped=0, trap_cause=0, retired=0; state IDLE.
- Minimum latency per instruction with zero-wait memory: 4 cycles (REQ, RESP, EXEC, COMMIT). First req_valid is 1 cycle after reset deasserts.
- Memory must return the response ≥1 cycle after acceptance; one outstanding request at most.
- Reset asserted mid-fetch or mid-commit: immediate return to reset values. Any in-flight response is dropped, and no wb_en is issued.
- wb_en and the PC update are in the same cycle; the new PC is visible on req_addr the next cycle.

## Configuration
- PC_SEQ_RETIRE_CNT_EN: defined → 32-bit io_retired counter implemented as above. Undefined → counter removed and io_retired tied to 0; all other behaviour is identical.

## Test plan
- Reset check: hold reset=0 and check every output at its reset value. Release reset: req_valid=1 with addr 8000_0000 one cycle later.
- Sequential flow: zero-wait memory, type 0, pc_next=PC+4 for 3 instructions → req_addr 8000_0000, 8000_0004, 8000_0008. wb_en pulses every 4 cycles; retired=3.
- Back-pressure: req_ready low 5 cycles, resp 3 cycles late → req_addr stable throughout; exactly one EXEC, then commit.
- Jump and halt: type 1 with pc_next=8000_0100 → next req_addr 8000_0100. Next instruction type 4 → halted=1, no wb_en, PC stays 8000_0100.
- Traps: is_unknown=1 → trapped=1, cause 1. Separately, pc_next=8000_0102 → cause 2, PC unchanged. Separately, req_ready never asserted → cause 3 after 255 cycles.
- Macro off: repeat the sequential flow → io_retired stays 0, all other outputs match.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/exec/commit sequencer owning the architectural PC
// Optional retired-instruction counter enabled by PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic [31:0] io_instruction,
  output logic [31:0] io_pc_count,
  input  logic [3:0]  io_pc_next_type,
  input  logic [31:0] io_pc_next,
  input  logic        io_is_unknown_instruction,
  output logic        io_exec,
  output logic        io_wb_en,
  output logic        io_halted,
  output logic        io_trapped,
  output logic [1:0]  io_trap_cause,
  output logic [31:0] io_retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_EXEC,
    S_COMMIT,
    S_HALT,
    S_TRAP
  } state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  // Last fetch cycle index that may still complete before the timeout trap.
  localparam logic [7:0]  TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  cause_q, cause_d;
  logic        wb_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      tmo_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    tmo_d   = '0;
    cause_d = cause_q;
    wb_en   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        tmo_d = tmo_q + 8'd1;
        if (tmo_q == TIMEOUT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (io_imem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        tmo_d = tmo_q + 8'd1;
        // A response arriving on the final allowed cycle beats the timeout.
        if (io_imem_resp_valid) begin
          instr_d = io_imem_resp_data;
          state_d = S_EXEC;
        end else if (tmo_q == TIMEOUT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end
      end
      S_EXEC: state_d = S_COMMIT;
      S_COMMIT: begin
        if (io_is_unknown_instruction || (io_pc_next_type == 4'd3)) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else if (io_pc_next_type == 4'd4) begin
          state_d = S_HALT;
        end else if (io_pc_next[1:0] != 2'b00) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          wb_en   = 1'b1;
          pc_d    = io_pc_next;
          state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign io_imem_req_valid = (state_q == S_REQ);
  assign io_imem_req_addr  = pc_q;
  assign io_instruction    = instr_q;
  assign io_pc_count       = pc_q;
  assign io_exec           = (state_q == S_EXEC);
  assign io_wb_en          = wb_en;
  assign io_halted         = (state_q == S_HALT);
  assign io_trapped        = (state_q == S_TRAP);
  assign io_trap_cause     = cause_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  assign retired_d = wb_en ? (retired_q + 32'd1) : retired_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign io_retired = retired_q;
`else
  assign io_retired = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer fetch/commit/halt/trap behaviour
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef PC_SEQ_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready = 1'b0;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid = 1'b0;
  logic [31:0] io_imem_resp_data = 32'h0;
  logic [31:0] io_instruction;
  logic [31:0] io_pc_count;
  logic [3:0]  io_pc_next_type = 4'd0;
  logic [31:0] io_pc_next = 32'h0;
  logic        io_is_unknown_instruction = 1'b0;
  logic        io_exec;
  logic        io_wb_en;
  logic        io_halted;
  logic        io_trapped;
  logic [1:0]  io_trap_cause;
  logic [31:0] io_retired;

  pc_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_imem_req_valid        (io_imem_req_valid),
    .io_imem_req_ready        (io_imem_req_ready),
    .io_imem_req_addr         (io_imem_req_addr),
    .io_imem_resp_valid       (io_imem_resp_valid),
    .io_imem_resp_data        (io_imem_resp_data),
    .io_instruction           (io_instruction),
    .io_pc_count              (io_pc_count),
    .io_pc_next_type          (io_pc_next_type),
    .io_pc_next               (io_pc_next),
    .io_is_unknown_instruction(io_is_unknown_instruction),
    .io_exec                  (io_exec),
    .io_wb_en                 (io_wb_en),
    .io_halted                (io_halted),
    .io_trapped               (io_trapped),
    .io_trap_cause            (io_trap_cause),
    .io_retired               (io_retired)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  longint      wb_cycles[$];
  longint      cycle = 0;
  logic [31:0] model_pc;
  logic [31:0] model_retired;

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, 32'(io_imem_req_valid), 32'd0);
    check({tag, "_req_addr"},  io_imem_req_addr, RESET_PC);
    check({tag, "_pc"},        io_pc_count, RESET_PC);
    check({tag, "_instr"},     io_instruction, NOP);
    check({tag, "_exec"},      32'(io_exec), 32'd0);
    check({tag, "_wb_en"},     32'(io_wb_en), 32'd0);
    check({tag, "_halted"},    32'(io_halted), 32'd0);
    check({tag, "_trapped"},   32'(io_trapped), 32'd0);
    check({tag, "_cause"},     32'(io_trap_cause), 32'd0);
    check({tag, "_retired"},   io_retired, 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    io_imem_req_ready = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_pc_next_type = 4'd0;
    io_pc_next = 32'h0;
    io_is_unknown_instruction = 1'b0;
    #1;
    check_reset_vals(tag);
    tick();
    #1;
  endtask

  task automatic release_reset();
    exp_addr_q.delete();
    exp_instr_q.delete();
    wb_cycles.delete();
    model_pc = RESET_PC;
    model_retired = 32'd0;
    exp_addr_q.push_back(RESET_PC);
    reset = 1'b1;
    tick();
    #1;
  endtask

  // Outcome: 0 commit, 1 halt, 2 trap unknown, 3 trap misaligned.
  task automatic run_instr(input int ready_wait, input int resp_wait, input logic [31:0] instr,
                           input logic [3:0] ptype, input logic [31:0] pnext, input logic unk);
    logic [31:0] addr_exp;
    logic [31:0] cur_pc;
    int          n;
    int          outcome;
    n = 0;
    while (!io_imem_req_valid && n < 16) begin
      tick();
      #1;
      n++;
    end
    check("req_seen", 32'(io_imem_req_valid), 32'd1);
    if (exp_addr_q.size() == 0) begin
      check("sb_addr_avail", 32'd0, 32'd1);
      addr_exp = model_pc;
    end else begin
      addr_exp = exp_addr_q.pop_front();
    end
    check("req_addr", io_imem_req_addr, addr_exp);
    for (int i = 0; i < ready_wait; i++) begin
      tick();
      #1;
      check("bp_req_valid", 32'(io_imem_req_valid), 32'd1);
      check("bp_req_addr", io_imem_req_addr, addr_exp);
    end
    io_imem_req_ready = 1'b1;
    tick();
    io_imem_req_ready = 1'b0;
    #1;
    check("resp_req_low", 32'(io_imem_req_valid), 32'd0);
    for (int i = 0; i < resp_wait; i++) begin
      tick();
      #1;
      check("resp_wait_exec", 32'(io_exec), 32'd0);
    end
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data = instr;
    exp_instr_q.push_back(instr);
    tick();
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data = $urandom;
    #1;
    check("exec", 32'(io_exec), 32'd1);
    check("exec_instr", io_instruction, exp_instr_q.pop_front());
    check("exec_pc", io_pc_count, model_pc);
    cur_pc = model_pc;
    tick();
    io_pc_next_type = ptype;
    io_pc_next = pnext;
    io_is_unknown_instruction = unk;
    #1;
    check("commit_exec_low", 32'(io_exec), 32'd0);
    check("commit_instr", io_instruction, instr);
    check("commit_pc", io_pc_count, cur_pc);
    if (unk || ptype == 4'd3) outcome = 2;
    else if (ptype == 4'd4) outcome = 1;
    else if (pnext[1:0] != 2'b00) outcome = 3;
    else outcome = 0;
    check("commit_wb_en", 32'(io_wb_en), (outcome == 0) ? 32'd1 : 32'd0);
    if (io_wb_en) wb_cycles.push_back(cycle);
    if (outcome == 0) begin
      model_pc = pnext;
      if (RET_EN) model_retired = model_retired + 32'd1;
      exp_addr_q.push_back(pnext);
    end
    tick();
    io_pc_next_type = 4'd0;
    io_pc_next = 32'h0;
    io_is_unknown_instruction = 1'b0;
    #1;
    check("post_retired", io_retired, model_retired);
    check("post_wb_low", 32'(io_wb_en), 32'd0);
    if (outcome == 0) begin
      check("post_req_valid", 32'(io_imem_req_valid), 32'd1);
    end else begin
      check("post_req_low", 32'(io_imem_req_valid), 32'd0);
      check("post_pc_hold", io_pc_count, cur_pc);
      check("post_halted", 32'(io_halted), (outcome == 1) ? 32'd1 : 32'd0);
      check("post_trapped", 32'(io_trapped), (outcome == 1) ? 32'd0 : 32'd1);
      check("post_cause", 32'(io_trap_cause), (outcome == 2) ? 32'd1 : (outcome == 3) ? 32'd2 : 32'd0);
    end
  endtask

  task automatic hold_terminal(input string tag, input logic h, input logic t, input logic [1:0] c,
                               input logic [31:0] pc);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check({tag, "_halted"},  32'(io_halted), 32'(h));
      check({tag, "_trapped"}, 32'(io_trapped), 32'(t));
      check({tag, "_cause"},   32'(io_trap_cause), 32'(c));
      check({tag, "_pc"},      io_pc_count, pc);
      check({tag, "_req"},     32'(io_imem_req_valid), 32'd0);
      check({tag, "_exec"},    32'(io_exec), 32'd0);
      check({tag, "_wb"},      32'(io_wb_en), 32'd0);
      check({tag, "_retired"}, io_retired, model_retired);
    end
  endtask

  initial begin
    int  n;
    bit  stable;

    // Reset values, then first request one cycle after release
    tick();
    apply_reset("rst");
    apply_reset("rst2");
    release_reset();
    check("first_req_valid", 32'(io_imem_req_valid), 32'd1);
    check("first_req_addr", io_imem_req_addr, RESET_PC);

    // Sequential flow, zero-wait memory
    run_instr(0, 0, 32'h0010_0093, 4'd0, model_pc + 32'd4, 1'b0);
    run_instr(0, 0, 32'h0020_0113, 4'd0, model_pc + 32'd4, 1'b0);
    run_instr(0, 0, 32'h0030_0193, 4'd0, model_pc + 32'd4, 1'b0);
    check("seq_wb_count", 32'(wb_cycles.size()), 32'd3);
    if (wb_cycles.size() == 3) begin
      check("seq_wb_gap1", 32'(wb_cycles[1] - wb_cycles[0]), 32'd4);
      check("seq_wb_gap2", 32'(wb_cycles[2] - wb_cycles[1]), 32'd4);
    end
    check("seq_retired", io_retired, RET_EN ? 32'd3 : 32'd0);
    check("seq_next_addr", io_imem_req_addr, 32'h8000_000C);

    // Back-pressure on request and late response
    run_instr(5, 3, 32'h0040_0213, 4'd0, model_pc + 32'd4, 1'b0);
    // Jump then halt
    run_instr(0, 0, 32'h0f00_006f, 4'd1, 32'h8000_0100, 1'b0);
    check("jump_addr", io_imem_req_addr, 32'h8000_0100);
    run_instr(0, 0, 32'h0010_0073, 4'd4, 32'h8000_0104, 1'b0);
    hold_terminal("halt", 1'b1, 1'b0, 2'd0, 32'h8000_0100);

    // Unknown-instruction trap (flag and type 3)
    apply_reset("rst_unk");
    release_reset();
    run_instr(0, 0, 32'hffff_ffff, 4'd0, RESET_PC + 32'd4, 1'b1);
    hold_terminal("trap_unk", 1'b0, 1'b1, 2'd1, RESET_PC);
    apply_reset("rst_t3");
    release_reset();
    run_instr(0, 0, 32'h0000_007f, 4'd3, RESET_PC + 32'd4, 1'b0);

    // Misaligned target
    apply_reset("rst_mis");
    release_reset();
    run_instr(0, 1, 32'h0010_0093, 4'd0, model_pc + 32'd4, 1'b0);
    run_instr(0, 0, 32'h0fe0_0067, 4'd2, 32'h8000_0102, 1'b0);
    hold_terminal("trap_mis", 1'b0, 1'b1, 2'd2, 32'h8000_0004);

    // Fetch timeout: req_ready never asserted
    apply_reset("rst_tmo");
    release_reset();
    n = 0;
    stable = 1'b1;
    while (!io_trapped && n < 400) begin
      if (io_imem_req_valid) n++;
      if (io_imem_req_addr !== RESET_PC) stable = 1'b0;
      tick();
      #1;
    end
    check("tmo_cycles", 32'(n), 32'd255);
    check("tmo_addr_stable", 32'(stable), 32'd1);
    check("tmo_trapped", 32'(io_trapped), 32'd1);
    check("tmo_cause", 32'(io_trap_cause), 32'd3);
    check("tmo_req_low", 32'(io_imem_req_valid), 32'd0);

    // Reset in the middle of a fetch drops the response
    apply_reset("rst_mid");
    release_reset();
    io_imem_req_ready = 1'b1;
    tick();
    io_imem_req_ready = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data = 32'hdead_beef;
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    io_imem_resp_valid = 1'b0;
    #1;
    check_reset_vals("midrst_hold");
    release_reset();

    // Random memory latencies
    for (int k = 0; k < 4; k++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                4'd0, model_pc + 32'd4 * 32'($urandom_range(1, 4)), 1'b0);
    end
    check("rand_retired", io_retired, RET_EN ? 32'd4 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
